// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

  // Byte address to word index; the caller keeps the low idx_w bits.
  function automatic logic [31:0] word_idx(input logic [63:0] addr, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((addr >> 2) & mask);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x XLEN simple dual-port RAM, registered read, read-before-write.
// Latency 1 cycle; no backpressure, a read is taken whenever re is high.
module imem_array #(
  parameter int               XLEN    = 32,
  parameter int               DEPTH   = 64,
  parameter int               IDX_W   = $clog2(DEPTH),
  parameter logic [XLEN-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself is cleared by the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= RST_VAL;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_sync.sv
// Instruction memory: NOP clear sweep after reset, then load port + 1-cycle fetch.
// Both ports stall (ready low) during the sweep; optional IMEM_BOUNDS_CHECK_EN adds fetch faults.
module imem_sync
  import imem_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter int              ADDR_W   = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              busy,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [XLEN-1:0]   load_data,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_instr,
  output logic              fetch_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  imem_state_t      state, state_nxt;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      fetch_word, load_word;
  logic [IDX_W-1:0] fetch_idx, load_idx;
  logic             fetch_acc, load_acc, fetch_bad, load_bad;
  logic             we, re;
  logic [IDX_W-1:0] waddr;
  logic [XLEN-1:0]  wdata, rdata;
  logic             unused_idx_bits;

  assign fetch_word = word_idx(64'(fetch_pc), IDX_W);
  assign load_word  = word_idx(64'(load_addr), IDX_W);
  assign fetch_idx  = fetch_word[IDX_W-1:0];
  assign load_idx   = load_word[IDX_W-1:0];
  assign unused_idx_bits = ^{fetch_word[31:IDX_W], load_word[31:IDX_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == IDX_W'(DEPTH - 1)) state_nxt = RUN;
  end

  always_comb begin
    busy        = 1'b1;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    if (state == RUN) begin
      busy        = 1'b0;
      load_ready  = 1'b1;
      fetch_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd4;
  logic fault_q;

  assign fetch_bad = (fetch_pc[1:0] != 2'b00) || (64'(fetch_pc) >= LIMIT);
  assign load_bad  = (load_addr[1:0] != 2'b00) || (64'(load_addr) >= LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       fault_q <= 1'b0;
    else if (fetch_acc) fault_q <= fetch_bad;
  end

  // A faulted fetch skips the array read, so the stale rdata is masked to NOP.
  assign fetch_fault = fetch_valid & fault_q;
  assign fetch_instr = fault_q ? NOP_WORD : rdata;
`else
  assign fetch_bad   = 1'b0;
  assign load_bad    = 1'b0;
  assign fetch_fault = 1'b0;
  assign fetch_instr = rdata;
`endif

  assign fetch_acc = fetch_req & fetch_ready;
  assign load_acc  = load_valid & load_ready;

  assign we    = (state == CLEAR) | (load_acc & ~load_bad);
  assign waddr = (state == CLEAR) ? clr_idx : load_idx;
  assign wdata = (state == CLEAR) ? NOP_WORD : load_data;
  assign re    = fetch_acc & ~fetch_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_valid <= 1'b0;
    else          fetch_valid <= fetch_acc;
  end

  imem_array #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .RST_VAL (NOP_WORD)
  ) u_array (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync with a queue of expected fetch responses.
module tb_imem_sync;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        fetch_req = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;

  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  logic        acc_prev = 1'b0;
  logic [31:0] last_instr = NOP;

  always #5 clk = ~clk;

  imem_sync dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .busy        (busy),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_req   (fetch_req),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp, input logic f);
    int k = 0;
    exp_q.push_back({f, exp});
    fetch_pc  = pc;
    fetch_req = 1'b1;
    while (fetch_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("fetch_ready_wait", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
    load_addr  = addr;
    load_data  = data;
    load_valid = 1'b1;
    check("load_ready", 32'(load_ready), 32'd1);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Response checker: latency, ordering, hold-when-idle and fault flag.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset_n) begin
      acc_prev   = 1'b0;
      last_instr = NOP;
    end else begin
      check("valid_timing", 32'(fetch_valid), 32'(acc_prev));
      if (fetch_valid) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_valid observed=%h expected=none", fetch_instr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("fetch_instr", fetch_instr, e[31:0]);
          check("fetch_fault", 32'(fetch_fault), 32'(e[32]));
          last_instr = e[31:0];
        end
      end else begin
        check("hold_instr", fetch_instr, last_instr);
        check("idle_fault", 32'(fetch_fault), 32'd0);
      end
      acc_prev = fetch_req && fetch_ready;
    end
  end

  initial begin
    int  nb;
    int  n;
    bit  done;

    @(negedge clk);
    check("rst_busy",        32'(busy),        32'd1);
    check("rst_load_ready",  32'(load_ready),  32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_instr", fetch_instr,      NOP);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);

    // Request held through the whole sweep; first response one cycle after RUN.
    exp_q.push_back({1'b0, NOP});
    fetch_pc  = 32'h0;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    nb = 0; n = 0; done = 1'b0;
    while (n < 200 && !done) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (fetch_valid) done = 1'b1;
      else if (!busy && fetch_req) begin
        @(posedge clk); #1;
        fetch_req = 1'b0;
      end
    end
    check("sweep_busy_cycles", 32'(nb), 32'd64);
    check("first_valid_cycle", 32'(n), 32'd66);
    @(posedge clk); #1;

    do_fetch(32'h40, NOP, 1'b0);
    do_fetch(32'hFC, NOP, 1'b0);

    do_load(32'h4, 32'h0030_0093);
    do_load(32'h8, 32'h0050_0113);

    exp_q.push_back({1'b0, 32'h0030_0093});
    fetch_pc = 32'h4; fetch_req = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 32'h0050_0113});
    fetch_pc = 32'h8;
    @(posedge clk); #1;
    fetch_req = 1'b0;

    // Same-edge load and fetch to 0xC: old word first, new word next.
    exp_q.push_back({1'b0, NOP});
    load_addr = 32'hC; load_data = 32'h0010_0133; load_valid = 1'b1;
    fetch_pc = 32'hC; fetch_req = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    exp_q.push_back({1'b0, 32'h0010_0133});
    @(posedge clk); #1;
    fetch_req = 1'b0;

`ifdef IMEM_BOUNDS_CHECK_EN
    do_fetch(32'h102, NOP, 1'b1);
    do_fetch(32'h100, NOP, 1'b1);
    do_load(32'h108, 32'hDEAD_BEEF);
    do_fetch(32'h8, 32'h0050_0113, 1'b0);
`else
    do_fetch(32'h104, 32'h0030_0093, 1'b0);
`endif

    do_load(32'h10, 32'h0070_0193);
    do_fetch(32'h10, 32'h0070_0193, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;

    // Reset from RUN, then again at cycle 20 of the sweep.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_sweep_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    nb = 0; n = 0; done = 1'b0;
    while (n < 200 && !done) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      else done = 1'b0 | 1'b1;
    end
    check("resweep_busy_cycles", 32'(nb), 32'd64);
    @(posedge clk); #1;

    do_fetch(32'h10, NOP, 1'b0);
    do_fetch(32'h4, NOP, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
# imem_sync

Clocked, parametrised instruction memory for the single-cycle RISC-V core. It replaces the combinational ROM with a one-write/one-read synchronous array. After reset it runs a self-clear sweep that fills every word with NOP, then accepts program words through a load handshake while serving fetches with one-cycle latency. The block sits between the PC register and the decoder; the program loader drives the load port.

## Interface
Parameters:
- XLEN, 32, instruction/data word width
- DEPTH, 64, number of words; power of two, ≥ 4
- ADDR_W, 32, byte-address width of `fetch_pc` and `load_addr`
- NOP_WORD, 32'h0000_0013, fill/reset instruction (`addi x0,x0,0`)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- busy  out  1  high while the clear sweep runs
- load_valid  in  1  loader has a word to write
- load_ready  out  1  block can accept a write
- load_addr  in  ADDR_W  byte address of the word
- load_data  in  XLEN  word to write
- fetch_req  in  1  fetch request
- fetch_ready  out  1  fetch can be accepted
- fetch_pc  in  ADDR_W  byte address to fetch
- fetch_valid  out  1  `fetch_instr` is valid this cycle
- fetch_instr  out  XLEN  fetched instruction
- fetch_fault  out  1  fetch address rejected (bounds check only)

## Operation
- Word index: `addr[IDX_W+1:2]`, where IDX_W = log2(DEPTH).
- States:
  - CLEAR (entered on reset): index counter `clr_idx` writes NOP_WORD to word `clr_idx` each cycle. `load_ready` = 0 and `fetch_ready` = 0. When the word at DEPTH-1 is written, the state moves to RUN.
  - RUN: `load_ready` = `fetch_ready` = 1. This state is terminal until the next reset.
- Load: a write happens on a clock edge where `load_valid && load_ready`. Data goes to the indexed word.
- Fetch: a fetch is accepted on a clock edge where `fetch_req && fetch_ready`. On the next cycle `fetch_valid` = 1 and `fetch_instr` = word contents.
  - Without an accepted request, `fetch_valid` = 0 and `fetch_instr` holds its last value.
- Simultaneous load and fetch to the same index: the fetch returns the old contents (read-before-write). The write still commits.
- `fetch_req` during CLEAR is ignored and produces no response. The requester must hold the request until `fetch_ready` is high.
- Reset asserted mid-sweep or mid-run: the state returns to CLEAR and `clr_idx` returns to 0. The array is not reset directly; the next sweep overwrites it.

## Timing
- Reset values:
  - `busy` = 1, `load_ready` = 0, `fetch_ready` = 0
  - `fetch_valid` = 0, `fetch_instr` = NOP_WORD, `fetch_fault` = 0
  - internal: state = CLEAR, `clr_idx` = 0
- Clear sweep: the first rising edge after reset release writes word 0, and edge k writes word k-1. After edge DEPTH, state = RUN and `busy` = 0.
- `load_ready`, `fetch_ready` and `busy` are decoded combinationally from the state register.
- Fetch latency is exactly 1 cycle. Back-to-back requests give back-to-back `fetch_valid`.
- A load written at edge n is visible to a fetch accepted at edge n+1 or later.

## Configuration
Macro: `IMEM_BOUNDS_CHECK_EN`.
- Defined:
  - A fetch is faulted if `fetch_pc[1:0]` ≠ 0 or `fetch_pc` ≥ DEPTH*4.
  - A faulted fetch gives `fetch_valid` = 1, `fetch_fault` = 1 and `fetch_instr` = NOP_WORD one cycle later.
  - A load with the same address conditions is accepted (handshake completes) but discarded.
- Undefined:
  - Low two address bits and upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - `fetch_fault` is tied to 0.

## Structure
- Package `imem_pkg` holds:
  - NOP_WORD default
  - state typedef `imem_state_t` {CLEAR, RUN}
  - function `word_idx(addr)` for index extraction
- Sub-module `imem_array`: a DEPTH×XLEN simple dual-port RAM with one write port, one registered read port and read-before-write behaviour. The top level holds the FSM, sweep counter, write mux (sweep vs. load), handshakes and the fault logic.

## Test plan
- Reset release, DEPTH=64 → `busy` high for exactly 64 cycles. Then fetch PC 0x0, 0x40 and 0xFC → each returns 32'h00000013 with `fetch_valid` one cycle after acceptance.
- Load 32'h00300093 at 0x4 and 32'h00500113 at 0x8, then fetch 0x4 and 0x8 back-to-back → instructions return on consecutive cycles in order.
- Same-edge load of 32'h00100133 to 0xC and fetch of 0xC → old NOP returned; a fetch of 0xC on the next edge returns 32'h00100133.
- Assert `reset_n` low at cycle 20 of the sweep, then release → `busy` high for another full 64 cycles; a word loaded before the reset reads back as NOP.
- With `IMEM_BOUNDS_CHECK_EN` defined, fetch 0x102 and 0x100 → `fetch_fault` = 1 with NOP for each. Without the macro, fetch 0x104 → returns word 1.
- `fetch_req` held high during CLEAR → no `fetch_valid` until the first cycle after RUN is entered plus one.
